// File: rtl/call_count_queue.sv
// call_count_queue
//   Services "get count" calls and queues the per-call results for a
//   downstream consumer. A static call adds its increment to a persistent
//   accumulator and returns the updated value. An automatic call returns
//   INIT + increment and leaves the accumulator alone. Results are held in a
//   DEPTH-entry FIFO and presented on a valid/ready port.
//
// Ports
//   clk         clock, all logic on rising edge
//   rst         synchronous active-high reset
//   req_valid   call request present
//   req_ready   call can be accepted this cycle (from rst and occupancy only)
//   req_static  1 = static call, 0 = automatic call
//   req_incr    amount added by this call
//   rsp_valid   FIFO head valid
//   rsp_ready   consumer accepts head
//   rsp_cnt     count returned by the call at the FIFO head (0 when empty)
//   rsp_static  req_static of the call at the FIFO head (0 when empty)
//   occupancy   entries currently held
//   wrapped     sticky flag, static accumulator carried out of WIDTH bits

module call_count_queue #(
    parameter int unsigned            WIDTH = 32,
    parameter int unsigned            DEPTH = 4,
    parameter logic [WIDTH-1:0]       INIT  = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_static,
    input  logic [WIDTH-1:0]           req_incr,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [WIDTH-1:0]           rsp_cnt,
    output logic                       rsp_static,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       wrapped
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] acc;
    logic [WIDTH:0]   static_sum;
    logic [WIDTH-1:0] result;
    logic             push;
    logic             pop;

    logic [WIDTH-1:0] cnt_mem    [DEPTH];
    logic             static_mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // No pop-to-push bypass: a full FIFO refuses even when a pop is pending.
    assign req_ready = !rst && (occupancy != FULL_CNT);
    assign rsp_valid = (occupancy != '0);

    assign push = req_valid && req_ready;
    assign pop  = rsp_valid && rsp_ready;

    // Extra bit catches the carry that sets the sticky wrap flag.
    assign static_sum = {1'b0, acc} + {1'b0, req_incr};

    always_comb begin
        result = INIT + req_incr;
        if (req_static) begin
            result = static_sum[WIDTH-1:0];
        end
    end

    // Head is masked while empty so the data port reads 0 after reset
    // without having to clear the storage array.
    assign rsp_cnt    = rsp_valid ? cnt_mem[rd_ptr]    : '0;
    assign rsp_static = rsp_valid ? static_mem[rd_ptr] : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= INIT;
            wrapped   <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (req_static) begin
                    acc <= static_sum[WIDTH-1:0];
                    if (static_sum[WIDTH]) begin
                        wrapped <= 1'b1;
                    end
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + (AW+1)'(1);
                2'b01:   occupancy <= occupancy - (AW+1)'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            cnt_mem[wr_ptr]    <= result;
            static_mem[wr_ptr] <= req_static;
        end
    end

endmodule

// File: tb/tb_call_count_queue.sv
module tb_call_count_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_valid8;
    logic        req_static;
    logic [31:0] req_incr;
    logic        rsp_ready;

    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_cnt;
    logic        rsp_static;
    logic [2:0]  occupancy;
    logic        wrapped;

    logic        req_ready8;
    logic        rsp_valid8;
    logic [7:0]  rsp_cnt8;
    logic        rsp_static8;
    logic [2:0]  occupancy8;
    logic        wrapped8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    call_count_queue u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_static (req_static),
        .req_incr   (req_incr),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_cnt    (rsp_cnt),
        .rsp_static (rsp_static),
        .occupancy  (occupancy),
        .wrapped    (wrapped)
    );

    call_count_queue #(.WIDTH(8)) u_dut8 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid8),
        .req_ready  (req_ready8),
        .req_static (req_static),
        .req_incr   (req_incr[7:0]),
        .rsp_valid  (rsp_valid8),
        .rsp_ready  (rsp_ready),
        .rsp_cnt    (rsp_cnt8),
        .rsp_static (rsp_static8),
        .occupancy  (occupancy8),
        .wrapped    (wrapped8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        req_valid8 = 1'b0;
        rsp_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic push(input logic st, input logic [31:0] incr);
        chk("push_ready", req_ready, 1);
        req_valid = 1'b1;
        req_static = st;
        req_incr = incr;
        step();
        req_valid = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [31:0] cnt, input logic st);
        chk({tag, "_valid"}, rsp_valid, 1);
        chk({tag, "_cnt"}, rsp_cnt, cnt);
        chk({tag, "_static"}, rsp_static, st);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic push8(input logic st, input logic [31:0] incr);
        chk("push8_ready", req_ready8, 1);
        req_valid8 = 1'b1;
        req_static = st;
        req_incr = incr;
        step();
        req_valid8 = 1'b0;
    endtask

    task automatic pop8_expect(input string tag, input logic [31:0] cnt);
        chk({tag, "_valid"}, rsp_valid8, 1);
        chk({tag, "_cnt"}, rsp_cnt8, cnt);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    initial begin
        req_static = 1'b0;
        req_incr = '0;
        do_reset();

        // reset values
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_cnt", rsp_cnt, 0);
        chk("rst_rsp_static", rsp_static, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_wrapped", wrapped, 0);
        chk("rst_req_ready", req_ready, 1);

        // two automatic calls stream through with rsp_ready held high
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_static = 1'b0;
        req_incr = 1;
        step();
        chk("auto1_valid", rsp_valid, 1);
        chk("auto1_cnt", rsp_cnt, 1);
        step();
        chk("auto2_cnt", rsp_cnt, 1);
        chk("auto2_occ", occupancy, 1);
        req_valid = 1'b0;
        step();
        chk("auto_drain_occ", occupancy, 0);
        rsp_ready = 1'b0;
        push(1'b1, 1);
        pop_expect("static_after_auto", 1, 1'b1);

        // static chain, automatic in between does not disturb acc
        do_reset();
        push(1'b1, 1);
        push(1'b1, 2);
        push(1'b1, 3);
        push(1'b0, 5);
        chk("chain_occ", occupancy, 4);
        pop_expect("chain0", 1, 1'b1);
        pop_expect("chain1", 3, 1'b1);
        pop_expect("chain2", 6, 1'b1);
        pop_expect("chain_auto", 5, 1'b0);
        push(1'b1, 1);
        pop_expect("chain3", 7, 1'b1);

        // fill to full, blocked 5th request, pop-only cycle, then accept
        do_reset();
        req_valid = 1'b1;
        req_static = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("fill_ready", req_ready, 1);
            req_incr = 10 + i;
            step();
        end
        chk("fill_occ", occupancy, 4);
        chk("fill_full_ready", req_ready, 0);
        req_incr = 14;
        step();
        chk("fill_held_occ", occupancy, 4);
        chk("fill_head", rsp_cnt, 10);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("fill_pop_occ", occupancy, 3);
        chk("fill_pop_head", rsp_cnt, 11);
        chk("fill_ready_again", req_ready, 1);
        step();
        req_valid = 1'b0;
        chk("fill_refill_occ", occupancy, 4);
        for (int i = 0; i < 4; i++) begin
            pop_expect("fill_order", 11 + i, 1'b0);
        end
        chk("fill_empty", rsp_valid, 0);

        // sustained push+pop at occupancy 2
        do_reset();
        push(1'b0, 20);
        push(1'b0, 21);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_static = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("pp_head", rsp_cnt, 20 + i);
            req_incr = 22 + i;
            step();
            chk("pp_occ", occupancy, 2);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        pop_expect("pp_tail0", 30, 1'b0);
        pop_expect("pp_tail1", 31, 1'b0);

        // 8-bit wrap on the static accumulator
        do_reset();
        push8(1'b1, 200);
        chk("wrap_before", wrapped8, 0);
        push8(1'b1, 100);
        chk("wrap_set", wrapped8, 1);
        pop8_expect("wrap0", 200);
        pop8_expect("wrap1", 44);
        for (int i = 0; i < 3; i++) begin
            push8(1'b0, 1);
            pop8_expect("wrap_auto", 1);
        end
        chk("wrap_sticky", wrapped8, 1);

        // reset in the middle of operation drops the in-flight request
        do_reset();
        chk("mid_wrapped8_clear", wrapped8, 0);
        push(1'b1, 50);
        push(1'b0, 1);
        push(1'b0, 2);
        chk("mid_occ", occupancy, 3);
        rst = 1'b1;
        req_valid = 1'b1;
        req_static = 1'b1;
        req_incr = 7;
        #1;
        chk("mid_ready_in_rst", req_ready, 0);
        step();
        rst = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_occ_clear", occupancy, 0);
        chk("mid_wrapped", wrapped, 0);
        chk("mid_rsp_cnt", rsp_cnt, 0);
        push(1'b1, 1);
        pop_expect("mid_static", 1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
